// File: rtl/dbg_bus_master.sv
// dbg_bus_master: UART-driven debug initiator for the PicoRV32-style native bus.
// Parses W/R/H/G byte commands from the receiver, performs one word access
// with a response timeout, and streams ACK/NAK or read data to the transmitter.
// Optional feature macro: DBG_AUTOINC_EN (post-increment address, 'w'/'r' cmds).
module dbg_bus_master #(
  parameter int         TIMEOUT  = 1024,
  parameter logic [7:0] ACK_BYTE = 8'h06,
  parameter logic [7:0] NAK_BYTE = 8'h15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        cpu_hold,
  output logic        rx_overrun
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  // Last timer value before the access is abandoned (timer counts bus edges).
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_is_write;
  logic [1:0]  r_byte_cnt;
  logic [1:0]  r_last_idx;
  logic [15:0] r_timer;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [23:0] r_rbuf;
  logic [3:0]  r_wstrb;
  logic        r_mem_valid;
  logic        r_tx_valid;
  logic [7:0]  r_tx_data;
  logic        r_cpu_hold;
  logic        r_rx_overrun;

  assign mem_valid  = r_mem_valid;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_wstrb  = r_wstrb;
  assign tx_valid   = r_tx_valid;
  assign tx_data    = r_tx_data;
  assign cpu_hold   = r_cpu_hold;
  assign rx_overrun = r_rx_overrun;

  // Command parser, bus sequencer and response streamer in one registered FSM.
  // NOTE: every state register is assigned with <= so all updates in this block
  // see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_is_write   <= 1'b0;
      r_byte_cnt   <= 2'd0;
      r_last_idx   <= 2'd0;
      r_timer      <= 16'd0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_rbuf       <= 24'd0;
      r_wstrb      <= 4'h0;
      r_mem_valid  <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= 8'h00;
      r_cpu_hold   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            r_byte_cnt <= 2'd0;
            r_last_idx <= 2'd0;
            case (rx_data)
              8'h57: begin r_is_write <= 1'b1; r_state <= S_ADDR; end
              8'h52: begin r_is_write <= 1'b0; r_state <= S_ADDR; end
              8'h48: begin
                r_cpu_hold <= 1'b1;
                r_tx_data  <= ACK_BYTE;
                r_tx_valid <= 1'b1;
                r_state    <= S_RESP;
              end
              8'h47: begin
                r_cpu_hold <= 1'b0;
                r_tx_data  <= ACK_BYTE;
                r_tx_valid <= 1'b1;
                r_state    <= S_RESP;
              end
`ifdef DBG_AUTOINC_EN
              8'h77: begin r_is_write <= 1'b1; r_state <= S_DATA; end
              8'h72: begin
                // Reuse the held address: straight onto the bus.
                r_is_write  <= 1'b0;
                r_wstrb     <= 4'h0;
                r_timer     <= 16'd0;
                r_mem_valid <= 1'b1;
                r_state     <= S_BUS;
              end
`endif
              default: begin
                r_tx_data  <= NAK_BYTE;
                r_tx_valid <= 1'b1;
                r_state    <= S_RESP;
              end
            endcase
          end
        end

        S_ADDR: begin
          if (rx_valid) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              // Final address byte: drop the host's byte-offset bits.
              r_addr     <= {rx_data, r_addr[31:10], 2'b00};
              r_byte_cnt <= 2'd0;
              if (r_is_write) begin
                r_state <= S_DATA;
              end else begin
                r_wstrb     <= 4'h0;
                r_timer     <= 16'd0;
                r_mem_valid <= 1'b1;
                r_state     <= S_BUS;
              end
            end else begin
              r_addr <= {rx_data, r_addr[31:8]};
            end
          end
        end

        S_DATA: begin
          if (rx_valid) begin
            r_wdata    <= {rx_data, r_wdata[31:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_byte_cnt  <= 2'd0;
              r_wstrb     <= 4'hF;
              r_timer     <= 16'd0;
              r_mem_valid <= 1'b1;
              r_state     <= S_BUS;
            end
          end
        end

        S_BUS: begin
          if (rx_valid) r_rx_overrun <= 1'b1;
          // Ready is checked first so a response on the final cycle succeeds.
          if (mem_ready) begin
            r_mem_valid <= 1'b0;
            r_tx_valid  <= 1'b1;
            r_state     <= S_RESP;
            if (r_is_write) begin
              r_tx_data  <= ACK_BYTE;
              r_last_idx <= 2'd0;
            end else begin
              r_tx_data  <= mem_rdata[7:0];
              r_rbuf     <= mem_rdata[31:8];
              r_last_idx <= 2'd3;
            end
`ifdef DBG_AUTOINC_EN
            r_addr <= r_addr + 32'd4;
`endif
          end else if (r_timer == TIMER_LAST) begin
            r_mem_valid <= 1'b0;
            r_tx_data   <= NAK_BYTE;
            r_tx_valid  <= 1'b1;
            r_last_idx  <= 2'd0;
            r_state     <= S_RESP;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end

        S_RESP: begin
          if (rx_valid) r_rx_overrun <= 1'b1;
          if (tx_ready) begin
            if (r_byte_cnt == r_last_idx) begin
              r_tx_valid <= 1'b0;
              r_byte_cnt <= 2'd0;
              r_state    <= S_IDLE;
            end else begin
              r_tx_data  <= r_rbuf[7:0];
              r_rbuf     <= {8'h00, r_rbuf[23:8]};
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
